// File: rtl/hilo_acc_reg_pkg.sv
// Shared definitions for the HI/LO accumulate register: FSM encoding,
// default data width and active levels for reset and write enables.
package hilo_acc_reg_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLow  = 2'd1,
        StHigh = 2'd2
    } acc_state_e;

    localparam int unsigned DefaultDataW = 32;
    localparam logic        RstActive    = 1'b1;
    localparam logic        WeActive     = 1'b1;

endpackage

// File: rtl/hilo_acc_reg_addsub.sv
// DATA_W-wide adder/subtractor shared by both accumulation phases.
// Subtraction inverts b; the caller supplies the +1 (or borrow) via cin_i.
module hilo_addsub #(
    parameter int unsigned DataW = 32
) (
    input  logic [DataW-1:0] a_i,
    input  logic [DataW-1:0] b_i,
    input  logic             sub_i,
    input  logic             cin_i,
    output logic [DataW-1:0] sum_o,
    output logic             cout_o
);

    logic [DataW-1:0] b_eff;
    logic [DataW:0]   result;

    always_comb begin
        b_eff  = sub_i ? ~b_i : b_i;
        result = {1'b0, a_i} + {1'b0, b_eff} + {{DataW{1'b0}}, cin_i};
        sum_o  = result[DataW-1:0];
        cout_o = result[DataW];
    end

endmodule

// File: rtl/hilo_acc_reg.sv
// HI/LO register pair with two-phase (LO then HI) MADD/MSUB accumulation.
// Define HILO_BYPASS_EN to forward same-cycle direct writes to hi_o/lo_o.
module hilo_acc_reg
    import hilo_acc_reg_pkg::*;
#(
    parameter int unsigned DATA_W = DefaultDataW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we_hi,
    input  logic                we_lo,
    input  logic [DATA_W-1:0]   hi_i,
    input  logic [DATA_W-1:0]   lo_i,
    input  logic                acc_valid,
    input  logic                acc_sub,
    input  logic [2*DATA_W-1:0] prod_i,
    output logic                acc_ready,
    output logic                acc_busy,
    output logic                acc_done,
    output logic [DATA_W-1:0]   hi_o,
    output logic [DATA_W-1:0]   lo_o
);

    acc_state_e           state_q, state_d;
    logic [DATA_W-1:0]    hi_q, hi_d;
    logic [DATA_W-1:0]    lo_q, lo_d;
    logic                 carry_q, carry_d;
    logic [2*DATA_W-1:0]  prod_q, prod_d;
    logic                 op_q, op_d;
    logic                 done_q, done_d;

    logic [DATA_W-1:0]    add_a, add_b, add_sum;
    logic                 add_cin, add_cout;
    logic                 wr_hi, wr_lo;

    assign wr_hi = (we_hi == WeActive);
    assign wr_lo = (we_lo == WeActive);

    // Operand mux: LO phase uses op_q as the two's-complement +1, HI phase the saved carry.
    always_comb begin
        add_a   = lo_q;
        add_b   = prod_q[DATA_W-1:0];
        add_cin = op_q;
        if (state_q == StHigh) begin
            add_a   = hi_q;
            add_b   = prod_q[2*DATA_W-1:DATA_W];
            add_cin = carry_q;
        end
    end

    hilo_addsub #(
        .DataW (DATA_W)
    ) u_addsub (
        .a_i    (add_a),
        .b_i    (add_b),
        .sub_i  (op_q),
        .cin_i  (add_cin),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        carry_d = carry_q;
        prod_d  = prod_q;
        op_d    = op_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (acc_valid) begin
                    prod_d  = prod_i;
                    op_d    = acc_sub;
                    state_d = StLow;
                end
            end
            StLow: begin
                lo_d    = add_sum;
                carry_d = add_cout;
                state_d = StHigh;
            end
            StHigh: begin
                hi_d    = add_sum;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // A direct write mid-accumulation cancels the pending phase entirely.
        if ((wr_hi || wr_lo) && (state_q != StIdle)) begin
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
            state_d = StIdle;
        end
        if (wr_hi) begin
            hi_d = hi_i;
        end
        if (wr_lo) begin
            lo_d = lo_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstActive) begin
            state_q <= StIdle;
            hi_q    <= '0;
            lo_q    <= '0;
            carry_q <= 1'b0;
            prod_q  <= '0;
            op_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            carry_q <= carry_d;
            prod_q  <= prod_d;
            op_q    <= op_d;
            done_q  <= done_d;
        end
    end

    assign acc_ready = (state_q == StIdle);
    assign acc_busy  = (state_q == StLow) || (state_q == StHigh);
    assign acc_done  = done_q;

`ifdef HILO_BYPASS_EN
    assign hi_o = wr_hi ? hi_i : hi_q;
    assign lo_o = wr_lo ? lo_i : lo_q;
`else
    assign hi_o = hi_q;
    assign lo_o = lo_q;
`endif

endmodule

// File: tb/tb_hilo_acc_reg.sv
// Self-checking bench for hilo_acc_reg: directed corner cases plus randomized
// accumulations checked against a 64-bit arithmetic model.
module tb_hilo_acc_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        we_hi, we_lo;
    logic [31:0] hi_i, lo_i;
    logic        acc_valid, acc_sub;
    logic [63:0] prod_i;
    logic        acc_ready, acc_busy, acc_done;
    logic [31:0] hi_o, lo_o;

    int checks = 0;
    int errors = 0;
    logic [63:0] m_acc;

    hilo_acc_reg dut (
        .clk       (clk),
        .rst       (rst),
        .we_hi     (we_hi),
        .we_lo     (we_lo),
        .hi_i      (hi_i),
        .lo_i      (lo_i),
        .acc_valid (acc_valid),
        .acc_sub   (acc_sub),
        .prod_i    (prod_i),
        .acc_ready (acc_ready),
        .acc_busy  (acc_busy),
        .acc_done  (acc_done),
        .hi_o      (hi_o),
        .lo_o      (lo_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        we_hi     = 1'b0;
        we_lo     = 1'b0;
        acc_valid = 1'b0;
    endtask

    task automatic write_both(input logic [31:0] h, input logic [31:0] l);
        we_hi = 1'b1;
        we_lo = 1'b1;
        hi_i  = h;
        lo_i  = l;
        tick();
        quiet();
        m_acc = {h, l};
    endtask

    task automatic run_acc(input string tag, input logic [63:0] p, input logic s);
        logic [63:0] exp;
        exp       = s ? (m_acc - p) : (m_acc + p);
        acc_valid = 1'b1;
        prod_i    = p;
        acc_sub   = s;
        tick();
        acc_valid = 1'b0;
        chk({tag, "_busy0"}, {63'd0, acc_busy}, 64'd1);
        chk({tag, "_rdy0"}, {63'd0, acc_ready}, 64'd0);
        tick();
        chk({tag, "_busy1"}, {63'd0, acc_busy}, 64'd1);
        chk({tag, "_lo_mid"}, {32'd0, lo_o}, {32'd0, exp[31:0]});
        chk({tag, "_hi_mid"}, {32'd0, hi_o}, {32'd0, m_acc[63:32]});
        tick();
        chk({tag, "_done"}, {63'd0, acc_done}, 64'd1);
        chk({tag, "_rdy"}, {63'd0, acc_ready}, 64'd1);
        chk({tag, "_hilo"}, {hi_o, lo_o}, exp);
        tick();
        chk({tag, "_done_clr"}, {63'd0, acc_done}, 64'd0);
        m_acc = exp;
    endtask

    initial begin
        int nacc;
        int ndone;
        int done_at [2];
        logic pre;

        rst = 1'b1;
        quiet();
        hi_i = '0; lo_i = '0; prod_i = '0; acc_sub = 1'b0;
        m_acc = '0;
        tick();
        tick();
        chk("rst_hilo", {hi_o, lo_o}, 64'd0);
        chk("rst_rdy", {63'd0, acc_ready}, 64'd1);
        chk("rst_busy", {63'd0, acc_busy}, 64'd0);
        chk("rst_done", {63'd0, acc_done}, 64'd0);
        rst = 1'b0;
        tick();

        // Direct write, with same-cycle visibility depending on bypass.
        we_hi = 1'b1; we_lo = 1'b1; hi_i = 32'h12345678; lo_i = 32'h9ABCDEF0;
        #1;
`ifdef HILO_BYPASS_EN
        chk("wr_bypass", {hi_o, lo_o}, 64'h12345678_9ABCDEF0);
`else
        chk("wr_nobypass", {hi_o, lo_o}, 64'd0);
`endif
        tick();
        quiet();
        chk("wr_after", {hi_o, lo_o}, 64'h12345678_9ABCDEF0);
        m_acc = 64'h12345678_9ABCDEF0;

        // Carry and borrow across the LO/HI boundary, plus silent wrap.
        write_both(32'h0, 32'hFFFFFFFF);
        run_acc("madd_carry", 64'd1, 1'b0);
        write_both(32'h1, 32'h0);
        run_acc("msub_borrow", 64'd1, 1'b1);
        write_both(32'hFFFFFFFF, 32'hFFFFFFFF);
        run_acc("madd_wrap", 64'd1, 1'b0);

        // Held acc_valid: second request only taken once ready again.
        write_both(32'h0, 32'h0);
        acc_valid = 1'b1; acc_sub = 1'b0; prod_i = 64'd5;
        nacc = 0; ndone = 0; done_at[0] = 0; done_at[1] = 0;
        for (int k = 0; k < 10; k++) begin
            pre = acc_valid && acc_ready;
            tick();
            if (pre) begin
                nacc++;
                prod_i = 64'd7;
                if (nacc == 2) acc_valid = 1'b0;
            end
            if (acc_done) begin
                if (ndone < 2) done_at[ndone] = k;
                ndone++;
            end
        end
        acc_valid = 1'b0;
        chk("held_accepts", nacc, 2);
        chk("held_dones", ndone, 2);
        chk("held_gap", done_at[1] - done_at[0], 3);
        chk("held_hilo", {hi_o, lo_o}, 64'd12);

        // Abort in HIGH: LO keeps its E1 result, HI takes the written value.
        write_both(32'h0, 32'hFFFFFFFF);
        acc_valid = 1'b1; prod_i = 64'd1; acc_sub = 1'b0;
        tick();
        acc_valid = 1'b0;
        tick();
        we_hi = 1'b1; hi_i = 32'hAAAA0000;
        tick();
        quiet();
        chk("abort_hilo", {hi_o, lo_o}, 64'hAAAA0000_00000000);
        chk("abort_rdy", {63'd0, acc_ready}, 64'd1);
        chk("abort_busy", {63'd0, acc_busy}, 64'd0);
        chk("abort_done0", {63'd0, acc_done}, 64'd0);
        tick();
        chk("abort_done1", {63'd0, acc_done}, 64'd0);
        chk("abort_stable", {hi_o, lo_o}, 64'hAAAA0000_00000000);

        // Abort in LOW via LO write: HI untouched, LO is the written value.
        write_both(32'h11112222, 32'h33334444);
        acc_valid = 1'b1; prod_i = 64'h0000000F_0000000F; acc_sub = 1'b0;
        tick();
        acc_valid = 1'b0;
        we_lo = 1'b1; lo_i = 32'h55556666;
        tick();
        quiet();
        tick();
        chk("abortlo_hilo", {hi_o, lo_o}, 64'h11112222_55556666);
        chk("abortlo_done", {63'd0, acc_done}, 64'd0);

        // Asynchronous reset in LOW takes effect before the next edge.
        write_both(32'h01234567, 32'h89ABCDEF);
        acc_valid = 1'b1; prod_i = 64'h5; acc_sub = 1'b0;
        tick();
        acc_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_hilo", {hi_o, lo_o}, 64'd0);
        chk("arst_busy", {63'd0, acc_busy}, 64'd0);
        chk("arst_rdy", {63'd0, acc_ready}, 64'd1);
        chk("arst_done", {63'd0, acc_done}, 64'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("arst_done2", {63'd0, acc_done}, 64'd0);
        chk("arst_hilo2", {hi_o, lo_o}, 64'd0);
        m_acc = '0;

        // Randomized accumulations against the 64-bit model.
        for (int i = 0; i < 20; i++) begin
            if (i % 4 == 0) write_both($urandom, $urandom);
            run_acc("rand", {$urandom, $urandom}, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
